// File: rtl/data_mem_responder_if.sv
// Data-memory request bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        stall;

   modport master (
      output mem_req, mem_we, mem_size, mem_addr, mem_wd,
      input  mem_rd, stall
   );

   modport slave (
      input  mem_req, mem_we, mem_size, mem_addr, mem_wd,
      output mem_rd, stall
   );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: word RAM with byte-lane stores, load extension and a
// programmable wait-state FSM that stalls the core until the response cycle.
module data_mem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   data_mem_responder_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = AW + 2;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES > 1 ? WAIT_STATES - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      size_q, size_d;
   logic [IW-1:0]   addr_q, addr_d;
   logic [31:0]     wd_q, wd_d;
   logic [31:0]     rd_hold_q, rd_hold_d;
   logic [31:0]     rdata_q;

   logic [31:0]     ram [DEPTH];
   logic            ram_re_c;
   logic [AW-1:0]   ram_ridx_c;
   logic            ram_we_c;
   logic [3:0]      ram_be_c;
   logic [31:0]     ram_wdata_c;
   logic [31:0]     load_ext_c;
   logic [7:0]      byte_c;
   logic [15:0]     half_c;
   logic            unused_addr_c;

   // Address bits above the RAM window wrap away.
   assign unused_addr_c = ^bus.mem_addr[31:IW];

   // State and latched-request registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         size_q    <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
         rd_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         rd_hold_q <= rd_hold_d;
      end
   end

   // Next-state logic; the RAM read is launched on the edge that enters RESP.
   always_comb begin : next_state_comb
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wd_d       = wd_q;
      ram_re_c   = 1'b0;
      ram_ridx_c = addr_q[IW-1:2];
      case (state_q)
         S_IDLE: begin
            if (bus.mem_req) begin
               we_d   = bus.mem_we;
               size_d = bus.mem_size;
               addr_d = bus.mem_addr[IW-1:0];
               wd_d   = bus.mem_wd;
               if (WAIT_STATES <= 1) begin
                  state_d    = S_RESP;
                  ram_re_c   = 1'b1;
                  ram_ridx_c = bus.mem_addr[IW-1:2];
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!bus.mem_req) begin
               state_d = S_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d  = S_RESP;
               ram_re_c = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane selection: load extension and store byte enables.
   always_comb begin : lane_comb
      byte_c = rdata_q[7:0];
      case (addr_q[1:0])
         2'd1:    byte_c = rdata_q[15:8];
         2'd2:    byte_c = rdata_q[23:16];
         2'd3:    byte_c = rdata_q[31:24];
         default: byte_c = rdata_q[7:0];
      endcase
      half_c = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (size_q)
         3'd0:    load_ext_c = {{24{byte_c[7]}}, byte_c};
         3'd4:    load_ext_c = {24'd0, byte_c};
         3'd1:    load_ext_c = {{16{half_c[15]}}, half_c};
         3'd5:    load_ext_c = {16'd0, half_c};
         default: load_ext_c = rdata_q;
      endcase
      case (size_q)
         3'd0, 3'd4: begin
            ram_be_c    = 4'b0001 << addr_q[1:0];
            ram_wdata_c = {4{wd_q[7:0]}};
         end
         3'd1, 3'd5: begin
            ram_be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            ram_wdata_c = {2{wd_q[15:0]}};
         end
         default: begin
            ram_be_c    = 4'b1111;
            ram_wdata_c = wd_q;
         end
      endcase
   end

   // Outputs: stall until RESP; load data visible in RESP and held afterwards.
   always_comb begin : output_comb
      rd_hold_d  = rd_hold_q;
      bus.mem_rd = rd_hold_q;
      ram_we_c   = 1'b0;
      bus.stall  = rst_i & bus.mem_req & (state_q != S_RESP);
      if (state_q == S_RESP) begin
         if (we_q) begin
            ram_we_c = 1'b1;
         end else begin
            bus.mem_rd = load_ext_c;
            rd_hold_d  = load_ext_c;
         end
      end
   end

   // Data RAM: contents survive reset, store commits on the edge ending RESP.
   always_ff @(posedge clk_i) begin
      if (ram_re_c) begin
         rdata_q <= ram[ram_ridx_c];
      end
      if (rst_i && ram_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be_c[b]) begin
               ram[addr_q[IW-1:2]][8*b +: 8] <= ram_wdata_c[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with a single wait state, one with three.
module tb_data_mem_responder;
   logic clk;
   logic rst1;
   logic rst3;
   int   checks;
   int   failures;
   int   cyc;

   data_mem_responder_if b1 ();
   data_mem_responder_if b3 ();

   data_mem_responder #(.DEPTH(1024), .WAIT_STATES(1)) dut1 (
      .clk_i (clk),
      .rst_i (rst1),
      .bus   (b1.slave)
   );

   data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
      .clk_i (clk),
      .rst_i (rst3),
      .bus   (b3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int sel, input logic req, input logic we,
                          input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd);
      if (sel == 1) begin
         b1.mem_req = req; b1.mem_we = we; b1.mem_size = size;
         b1.mem_addr = addr; b1.mem_wd = wd;
      end else begin
         b3.mem_req = req; b3.mem_we = we; b3.mem_size = size;
         b3.mem_addr = addr; b3.mem_wd = wd;
      end
   endtask

   function automatic logic get_stall(input int sel);
      return (sel == 1) ? b1.stall : b3.stall;
   endfunction

   function automatic logic [31:0] get_rd(input int sel);
      return (sel == 1) ? b1.mem_rd : b3.mem_rd;
   endfunction

   // Called just after a rising edge; returns RESP-cycle data and stall count.
   task automatic access(input int sel, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int nst);
      bit done;
      nst  = 0;
      rd   = '0;
      done = 1'b0;
      set_req(sel, 1'b1, we, size, addr, wd);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (get_stall(sel)) begin
            nst++;
            @(posedge clk);
            #1;
         end else begin
            rd   = get_rd(sel);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL access_timeout sel=%0d addr=%h", sel, addr);
      end
      @(posedge clk);
      #1;
      set_req(sel, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
   endtask

   logic [31:0] rd;
   int          nst;
   int          c0;

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst1     = 1'b0;
      rst3     = 1'b0;
      set_req(1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
      set_req(3, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
      #12;
      chk("reset_stall_forced", 32'(get_stall(1)), 32'h0);
      chk("reset_rd_zero", get_rd(1), 32'h0);
      set_req(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      #1;
      rst1 = 1'b1;
      rst3 = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_stall_low", 32'(get_stall(1)), 32'h0);

      // Word store and load, one wait state
      access(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, nst);
      chk("sw_stall_cycles", 32'(nst), 32'd1);
      chk("sw_rd_unchanged", rd, 32'h0);
      access(1, 1'b0, 3'd2, 32'h10, 32'h0, rd, nst);
      chk("lw_stall_cycles", 32'(nst), 32'd1);
      chk("lw_data", rd, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd_hold_idle", get_rd(1), 32'hDEADBEEF);
      @(posedge clk);
      #1;

      // Byte store into top lane
      access(1, 1'b1, 3'd0, 32'h13, 32'h00000080, rd, nst);
      chk("sb_rd_unchanged", rd, 32'hDEADBEEF);
      access(1, 1'b0, 3'd2, 32'h10, 32'h0, rd, nst);
      chk("lw_after_sb", rd, 32'h80ADBEEF);
      access(1, 1'b0, 3'd0, 32'h13, 32'h0, rd, nst);
      chk("lb_sign", rd, 32'hFFFFFF80);
      access(1, 1'b0, 3'd4, 32'h13, 32'h0, rd, nst);
      chk("lbu_zero", rd, 32'h00000080);
      access(1, 1'b0, 3'd0, 32'h10, 32'h0, rd, nst);
      chk("lb_lane0", rd, 32'hFFFFFFEF);
      access(1, 1'b0, 3'd1, 32'h10, 32'h0, rd, nst);
      chk("lh_low", rd, 32'hFFFFBEEF);
      access(1, 1'b0, 3'd5, 32'h12, 32'h0, rd, nst);
      chk("lhu_high", rd, 32'h000080AD);
      access(1, 1'b0, 3'd3, 32'h11, 32'h0, rd, nst);
      chk("size3_as_word", rd, 32'h80ADBEEF);

      // Halfword store over a zeroed word
      access(1, 1'b1, 3'd2, 32'h20, 32'h0, rd, nst);
      access(1, 1'b1, 3'd1, 32'h22, 32'hFFFF8001, rd, nst);
      access(1, 1'b0, 3'd1, 32'h22, 32'h0, rd, nst);
      chk("lh_sign", rd, 32'hFFFF8001);
      access(1, 1'b0, 3'd5, 32'h23, 32'h0, rd, nst);
      chk("lhu_addr0_ignored", rd, 32'h00008001);
      access(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, nst);
      chk("lw_after_sh", rd, 32'h80010000);

      // Address wrap modulo 4 KiB
      access(1, 1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, rd, nst);
      access(1, 1'b0, 3'd2, 32'h0, 32'h0, rd, nst);
      chk("addr_wrap", rd, 32'hA5A5A5A5);

      // Three wait states, back-to-back loads
      access(3, 1'b1, 3'd2, 32'h30, 32'h13572468, rd, nst);
      chk("w3_sw_stall_cycles", 32'(nst), 32'd3);
      c0 = cyc;
      access(3, 1'b0, 3'd2, 32'h30, 32'h0, rd, nst);
      chk("w3_lw1_stall_cycles", 32'(nst), 32'd3);
      chk("w3_lw1_data", rd, 32'h13572468);
      access(3, 1'b0, 3'd1, 32'h30, 32'h0, rd, nst);
      chk("w3_lw2_stall_cycles", 32'(nst), 32'd3);
      chk("w3_lh2_data", rd, 32'h00002468);
      chk("w3_back_to_back_cycles", 32'(cyc - c0), 32'd8);

      // Reset during WAIT aborts the store
      access(3, 1'b1, 3'd2, 32'h40, 32'h11112222, rd, nst);
      set_req(3, 1'b1, 1'b1, 3'd2, 32'h40, 32'h12345678);
      @(posedge clk);
      #1;
      rst3 = 1'b0;
      #1;
      chk("reset_in_wait_stall", 32'(get_stall(3)), 32'h0);
      chk("reset_in_wait_rd", get_rd(3), 32'h0);
      set_req(3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      rst3 = 1'b1;
      @(posedge clk);
      #1;
      access(3, 1'b0, 3'd2, 32'h40, 32'h0, rd, nst);
      chk("reset_abort_no_write", rd, 32'h11112222);

      // Request dropped in WAIT aborts the store
      access(3, 1'b1, 3'd2, 32'h80, 32'h01020304, rd, nst);
      set_req(3, 1'b1, 1'b1, 3'd2, 32'h80, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      set_req(3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("drop_req_stall", 32'(get_stall(3)), 32'h0);
      access(3, 1'b0, 3'd2, 32'h80, 32'h0, rd, nst);
      chk("drop_req_no_write", rd, 32'h01020304);
      chk("drop_req_recover_stall", 32'(nst), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
